ifu_fetch_queue: RTL and testbench

Parametrised successor to the IFU front end that merges the start synchroniser output, the PC generator and the IMem fetch into one block. It issues multi-instruction fetch requests to a 1-cycle-latency synchronous instruction memory and buffers the returned bundles in a credit-controlled fetch queue. It also handles BRU flush/redirect and start-PC launch, and detects unaligned PCs. It sits between the 2FF start synchroniser / BRU and the decode stage.

---
 rtl/ifu_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// IFU front end: PC generator, 1-cycle IMem fetch issue and credit-controlled fetch queue.
// Optional IFU_FQ_BYPASS_EN forwards a returning bundle straight to decode when the queue is empty.
module ifu_fetch_queue #(
  parameter int PC_WIDTH    = 32,
  parameter int INST_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int FQ_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_pulse,
  input  logic [PC_WIDTH-1:0]               start_pc,
  input  logic                              bru_flush,
  input  logic [PC_WIDTH-1:0]               bru_redir_pc,
  output logic                              imem_req,
  output logic [PC_WIDTH-1:0]               imem_addr,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] imem_rd_data,
  output logic                              fq_valid,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] fq_inst,
  output logic [PC_WIDTH-1:0]               fq_pc,
  input  logic                              fq_ready,
  output logic                              core_running,
  output logic                              pc_unalign_err
);

  localparam int BUNDLE_W = FETCH_WIDTH * INST_WIDTH;
  localparam int PTR_W    = $clog2(FQ_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam logic [PC_WIDTH-1:0] STRIDE     = PC_WIDTH'(FETCH_WIDTH * 4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(FETCH_WIDTH * 4 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                err_q, err_d;
  logic                inflight_q;
  logic [PC_WIDTH-1:0] resp_pc_q;

  logic [BUNDLE_W-1:0] inst_mem [FQ_DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [FQ_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                redirect, kill, rsp_live, push, pop, credit_ok;
  logic [CNT_W:0]      occupancy;

  assign redirect  = (state_q == S_RUN) && bru_flush && !start_pulse;
  assign kill      = start_pulse || redirect;
  // The response returning in a flush/start cycle belongs to the old stream.
  assign rsp_live  = inflight_q && !kill;
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok = occupancy < (CNT_W + 1)'(FQ_DEPTH);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_d    = err_q;
    imem_req = 1'b0;
    if (start_pulse) begin
      if (start_pc[1:0] != 2'b00) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        state_d = S_RUN;
        err_d   = 1'b0;
        pc_d    = start_pc & ALIGN_MASK;
      end
    end else if (redirect) begin
      if (bru_redir_pc[1:0] != 2'b00) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        pc_d = bru_redir_pc & ALIGN_MASK;
      end
    end else if (state_q == S_RUN && credit_ok) begin
      imem_req = 1'b1;
      pc_d     = pc_q + STRIDE;
    end
  end

  assign imem_addr      = pc_q;
  assign core_running   = (state_q == S_RUN);
  assign pc_unalign_err = err_q;

`ifdef IFU_FQ_BYPASS_EN
  logic byp;
  assign byp      = rsp_live && (count_q == '0);
  assign fq_valid = (count_q != '0) || byp;
  assign fq_inst  = (count_q != '0) ? inst_mem[rd_ptr_q] : (byp ? imem_rd_data : '0);
  assign fq_pc    = (count_q != '0) ? pc_mem[rd_ptr_q]   : (byp ? resp_pc_q    : '0);
  assign pop      = (count_q != '0) && fq_ready && !kill;
  assign push     = rsp_live && !(byp && fq_ready);
`else
  assign fq_valid = (count_q != '0);
  assign fq_inst  = fq_valid ? inst_mem[rd_ptr_q] : '0;
  assign fq_pc    = fq_valid ? pc_mem[rd_ptr_q]   : '0;
  assign pop      = fq_valid && fq_ready && !kill;
  assign push     = rsp_live;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      resp_pc_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      inflight_q <= imem_req;
      if (imem_req) resp_pc_q <= pc_q;
      if (kill) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= imem_rd_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

  fq_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == CNT_W'(FQ_DEPTH)));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: IMem model where word i holds i, scoreboard of issued bundles, directed scenarios.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_pulse, bru_flush, fq_ready;
  logic [31:0] start_pc, bru_redir_pc;
  logic        imem_req, fq_valid, core_running, pc_unalign_err;
  logic [31:0] imem_addr, fq_pc;
  logic [63:0] imem_rd_data, fq_inst;

`ifdef IFU_FQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_pop = 0;

  always #5 clk = ~clk;

  ifu_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .start_pulse(start_pulse), .start_pc(start_pc),
    .bru_flush(bru_flush), .bru_redir_pc(bru_redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
    .fq_valid(fq_valid), .fq_inst(fq_inst), .fq_pc(fq_pc), .fq_ready(fq_ready),
    .core_running(core_running), .pc_unalign_err(pc_unalign_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] bundle_of(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    return {w + 32'd1, w};
  endfunction

  // Synchronous IMem: data for a request appears the following cycle.
  always @(posedge clk) begin
    if (imem_req) imem_rd_data <= bundle_of(imem_addr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb.delete();
    else begin
      if (start_pulse || bru_flush) sb.delete();
      if (imem_req) sb.push_back({imem_addr, bundle_of(imem_addr)});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && fq_valid && fq_ready && !(start_pulse || bru_flush)) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_pc", fq_pc, e.pc);
        chk("sb_inst", fq_inst, e.inst);
        n_pop++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_valid"}, fq_valid, 0);
    chk({tag, "_inst"}, fq_inst, 0);
    chk({tag, "_pc"}, fq_pc, 0);
    chk({tag, "_run"}, core_running, 0);
    chk({tag, "_err"}, pc_unalign_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  nreq;
    bit  got;
    rst_n = 1'b0; start_pulse = 1'b0; bru_flush = 1'b0; fq_ready = 1'b0;
    start_pc = '0; bru_redir_pc = '0;
    repeat (3) @(posedge clk);
    smp();
    chk_all_zero("reset");
    cyc(); rst_n = 1'b1;

    // Launch at 0x10 with decode always ready
    cyc(); start_pulse = 1'b1; start_pc = 32'h10; fq_ready = 1'b1;
    smp(); chk("start_no_req", imem_req, 0);
    cyc(); start_pulse = 1'b0;
    smp(); chk("launch_run", core_running, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin cyc(); smp(); end
      chk("launch_req", imem_req, 1);
      chk("launch_addr", imem_addr, 32'h10 + 32'(8 * k));
      if (k < LAT) chk("launch_lat_idle", fq_valid, 0);
      if (k == LAT) begin
        chk("launch_valid", fq_valid, 1);
        chk("launch_pc", fq_pc, 32'h10);
        chk("launch_inst", fq_inst, {32'd5, 32'd4});
      end
    end

    // Backpressure: queue fills, issue stops after FQ_DEPTH requests
    cyc(); start_pulse = 1'b1; start_pc = 32'h10; fq_ready = 1'b0;
    smp();
    cyc(); start_pulse = 1'b0;
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      smp(); if (imem_req) nreq++;
      cyc();
    end
    smp();
    chk("bp_nreq", 64'(nreq), 4);
    chk("bp_req_stop", imem_req, 0);
    chk("bp_valid", fq_valid, 1);
    cyc(); fq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp(); chk("bp_order", fq_pc, 32'h10 + 32'(8 * k));
      cyc();
    end
    got = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      smp(); if (imem_req) got = 1;
      cyc();
    end
    chk("bp_resume", got, 1);

    // Flush while the 0x20 request is in flight
    start_pulse = 1'b1; start_pc = 32'h10;
    cyc(); start_pulse = 1'b0;
    cyc();
    cyc(); smp(); chk("flush_setup", imem_addr, 32'h20);
    cyc(); bru_flush = 1'b1; bru_redir_pc = 32'h100;
    smp(); chk("flush_no_req", imem_req, 0);
    cyc(); bru_flush = 1'b0;
    smp();
    chk("flush_addr", imem_addr, 32'h100);
    chk("flush_req", imem_req, 1);
    chk("flush_empty", fq_valid, 0);
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      cyc(); smp();
      if (fq_valid) begin got = 1; chk("flush_pc", fq_pc, 32'h100); end
    end
    if (!got) chk("flush_timeout", 0, 1);

    // Unaligned redirect halts; a later start recovers
    cyc(); bru_flush = 1'b1; bru_redir_pc = 32'h41;
    smp();
    cyc(); bru_flush = 1'b0;
    smp();
    chk("halt_run", core_running, 0);
    chk("halt_err", pc_unalign_err, 1);
    chk("halt_req", imem_req, 0);
    chk("halt_valid", fq_valid, 0);
    cyc(); smp(); chk("halt_stays", imem_req, 0);
    cyc(); start_pulse = 1'b1; start_pc = 32'h80;
    smp();
    cyc(); start_pulse = 1'b0;
    smp();
    chk("recover_err", pc_unalign_err, 0);
    chk("recover_addr", imem_addr, 32'h80);
    chk("recover_req", imem_req, 1);

    // PC wrap
    cyc(); start_pulse = 1'b1; start_pc = 32'hFFFF_FFF8;
    smp();
    cyc(); start_pulse = 1'b0;
    smp(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    cyc(); smp(); chk("wrap_addr1", imem_addr, 32'h0);
    repeat (5) cyc();

    // start_pulse wins over a simultaneous bru_flush
    start_pulse = 1'b1; start_pc = 32'h200; bru_flush = 1'b1; bru_redir_pc = 32'h300;
    smp();
    cyc(); start_pulse = 1'b0; bru_flush = 1'b0;
    smp(); chk("collide_addr", imem_addr, 32'h200);

    // Reset mid-run with a non-empty queue
    cyc(); fq_ready = 1'b0;
    repeat (3) cyc();
    smp(); chk("pre_rst_valid", fq_valid, 1);
    cyc(); rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    cyc(); rst_n = 1'b1;
    smp(); chk("post_rst_idle", core_running, 0);
    chk("pops_seen", n_pop >= 8, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
